// File: rtl/alu_cond_pkg.sv
// Shared types for the Execute-stage condition/flag unit: condition codes,
// NZCV flag indices and the flag-write / E-M control bundles.
package alu_cond_pkg;

  localparam int FLAG_W = 4;
  localparam int COND_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  // nz -> FlagWriteE[1], cv -> FlagWriteE[0]
  typedef struct packed {
    logic nz;
    logic cv;
  } flagwrite_t;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
  } em_ctrl_t;

  // Merge the ALU flags into the stored flags under the two write groups.
  function automatic logic [FLAG_W-1:0] merge_flags(
    input logic [FLAG_W-1:0] cur,
    input logic [FLAG_W-1:0] alu,
    input flagwrite_t        fw
  );
    logic [FLAG_W-1:0] nxt;
    nxt = cur;
    if (fw.nz) begin
      nxt[FLAG_N] = alu[FLAG_N];
      nxt[FLAG_Z] = alu[FLAG_Z];
    end
    if (fw.cv) begin
      nxt[FLAG_C] = alu[FLAG_C];
      nxt[FLAG_V] = alu[FLAG_V];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu_cond_unit_cond_check.sv
// Purely combinational condition evaluator: 4-bit condition field against
// stored NZCV flags. The reserved code never passes.
module cond_check
  import alu_cond_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = ~(n ^ v);
      COND_LT: pass = n ^ v;
      COND_GT: pass = ~z & ~(n ^ v);
      COND_LE: pass = z | (n ^ v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_cond_unit.sv
// Execute-stage condition/flag unit: flag register, condition gating of
// controls and the E/M control register. Optional counters: ALU_COND_PERF_EN.
module alu_cond_unit
  import alu_cond_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic [COND_W-1:0] CondE,
  input  logic [1:0]        FlagWriteE,
  input  logic [FLAG_W-1:0] ALUFlags,
  input  logic              PCSrcE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  output logic              CondExE,
  output logic              PCSrcGatedE,
  output logic              PCSrcM,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [FLAG_W-1:0] FlagsQ
`ifdef ALU_COND_PERF_EN
  ,
  output logic [31:0]       ExecCount,
  output logic [31:0]       SquashCount
`endif
);

  logic       condpass;
  flagwrite_t fw;
  em_ctrl_t   em_d, em_q;

  // Evaluated on the stored flags only; ALUFlags never reaches an output.
  cond_check u_cond_check (
    .cond  (CondE),
    .flags (FlagsQ),
    .pass  (condpass)
  );

  assign CondExE     = condpass & ~FlushE;
  assign PCSrcGatedE = PCSrcE & CondExE;
  assign fw          = flagwrite_t'(FlagWriteE);

  assign em_d.pcsrc    = PCSrcGatedE;
  assign em_d.regwrite = RegWriteE & CondExE;
  assign em_d.memwrite = MemWriteE & CondExE;

  always_ff @(posedge clk) begin
    if (reset)
      FlagsQ <= '0;
    else if (~StallE && CondExE)
      FlagsQ <= merge_flags(FlagsQ, ALUFlags, fw);
  end

  always_ff @(posedge clk) begin
    if (reset)
      em_q <= '0;
    else if (~StallE)
      em_q <= em_d;
  end

  assign PCSrcM    = em_q.pcsrc;
  assign RegWriteM = em_q.regwrite;
  assign MemWriteM = em_q.memwrite;

`ifdef ALU_COND_PERF_EN
  // Every unstalled cycle lands in exactly one of the two counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ExecCount   <= '0;
      SquashCount <= '0;
    end else if (~StallE) begin
      if (CondExE) ExecCount   <= ExecCount + 32'd1;
      else         SquashCount <= SquashCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cond_unit.sv
// Self-checking bench for alu_cond_unit: directed steps then random cycles
// against an NZCV reference model. Counter checks follow ALU_COND_PERF_EN.
module tb_alu_cond_unit;

  logic        clk = 1'b0;
  logic        reset, StallE, FlushE, PCSrcE, RegWriteE, MemWriteE;
  logic [3:0]  CondE, ALUFlags;
  logic [1:0]  FlagWriteE;
  logic        CondExE, PCSrcGatedE, PCSrcM, RegWriteM, MemWriteM;
  logic [3:0]  FlagsQ;
  logic [31:0] ExecCount, SquashCount;

  int ncmp  = 0;
  int nfail = 0;

  // reference state
  logic [3:0]  mf;
  logic        mpc, mrw, mmw;
  logic [31:0] mex, msq;

  always #5 clk = ~clk;

  alu_cond_unit dut (
    .clk         (clk),
    .reset       (reset),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .CondE       (CondE),
    .FlagWriteE  (FlagWriteE),
    .ALUFlags    (ALUFlags),
    .PCSrcE      (PCSrcE),
    .RegWriteE   (RegWriteE),
    .MemWriteE   (MemWriteE),
    .CondExE     (CondExE),
    .PCSrcGatedE (PCSrcGatedE),
    .PCSrcM      (PCSrcM),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .FlagsQ      (FlagsQ)
`ifdef ALU_COND_PERF_EN
    ,
    .ExecCount   (ExecCount),
    .SquashCount (SquashCount)
`endif
  );

`ifndef ALU_COND_PERF_EN
  assign ExecCount   = '0;
  assign SquashCount = '0;
`endif

  // Conditions come in complementary pairs: even code tests a predicate,
  // the odd code its inverse. 1110 always, 1111 never.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return (c == 4'he);
    endcase
    return base ^ c[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stl, input logic fl,
                       input logic [3:0] c, input logic [1:0] fwr, input logic [3:0] alu,
                       input logic pcs, input logic rw, input logic mw);
    reset = rst; StallE = stl; FlushE = fl; CondE = c; FlagWriteE = fwr;
    ALUFlags = alu; PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw;
  endtask

  // Check combinational outputs, advance model and DUT one edge, check state.
  task automatic cyc();
    logic ce;
    #1;
    ce = ref_pass(CondE, mf) && !FlushE;
    check("condex", {31'd0, CondExE}, {31'd0, ce});
    check("pcsgated", {31'd0, PCSrcGatedE}, {31'd0, PCSrcE && ce});
    if (reset) begin
      mf = '0; mpc = 0; mrw = 0; mmw = 0; mex = '0; msq = '0;
    end else if (!StallE) begin
      if (ce && FlagWriteE[1]) mf[3:2] = ALUFlags[3:2];
      if (ce && FlagWriteE[0]) mf[1:0] = ALUFlags[1:0];
      mpc = PCSrcE && ce;
      mrw = RegWriteE && ce;
      mmw = MemWriteE && ce;
      if (ce) mex = mex + 1;
      else    msq = msq + 1;
    end
    @(posedge clk); #1;
    check("flagsq", {28'd0, FlagsQ}, {28'd0, mf});
    check("pcsrcm", {31'd0, PCSrcM}, {31'd0, mpc});
    check("regwritem", {31'd0, RegWriteM}, {31'd0, mrw});
    check("memwritem", {31'd0, MemWriteM}, {31'd0, mmw});
`ifdef ALU_COND_PERF_EN
    check("execcount", ExecCount, mex);
    check("squashcount", SquashCount, msq);
`endif
  endtask

  initial begin
    mf = '0; mpc = 0; mrw = 0; mmw = 0; mex = '0; msq = '0;
    drive(1, 0, 0, 4'he, 2'b11, 4'hf, 1, 1, 1);
    @(posedge clk); #1;
    cyc();
    check("reset_flags", {28'd0, FlagsQ}, 32'h0);
    check("reset_pcsrcm", {31'd0, PCSrcM}, 32'h0);

    // EQ fails, NE passes on cleared flags
    drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0); #1;
    check("eq_after_reset", {31'd0, CondExE}, 32'h0);
    cyc();
    drive(0, 0, 0, 4'h1, 2'b00, 4'h0, 0, 0, 0); #1;
    check("ne_after_reset", {31'd0, CondExE}, 32'h1);
    cyc();

    // AL writes Z, next instruction sees it
    drive(0, 0, 0, 4'he, 2'b11, 4'h4, 0, 0, 0); cyc();
    drive(0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0); #1;
    check("z_written", {28'd0, FlagsQ}, 32'h4);
    check("eq_sees_z", {31'd0, CondExE}, 32'h1);
    cyc();

    // N=1,V=0 -> GE fails, RegWrite gated
    drive(0, 0, 0, 4'he, 2'b11, 4'h8, 0, 0, 0); cyc();
    drive(0, 0, 0, 4'ha, 2'b00, 4'h0, 0, 1, 0); #1;
    check("ge_fails", {31'd0, CondExE}, 32'h0);
    cyc();
    check("ge_regwritem", {31'd0, RegWriteM}, 32'h0);

    // partial flag writes
    drive(0, 0, 0, 4'he, 2'b11, 4'h3, 0, 0, 0); cyc();
    drive(0, 0, 0, 4'he, 2'b10, 4'hf, 0, 0, 0); cyc();
    check("nz_only", {28'd0, FlagsQ}, 32'hf);
    drive(0, 0, 0, 4'he, 2'b11, 4'h0, 0, 0, 0); cyc();
    drive(0, 0, 0, 4'he, 2'b01, 4'hf, 0, 0, 0); cyc();
    check("cv_only", {28'd0, FlagsQ}, 32'h3);

    // stall holds over flush; flush applies on release
    drive(0, 0, 0, 4'he, 2'b00, 4'h0, 1, 1, 1); cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 4'he, 2'b11, 4'hc, 1, 1, 1); cyc();
    end
    check("stall_hold_regw", {31'd0, RegWriteM}, 32'h1);
    check("stall_hold_flags", {28'd0, FlagsQ}, 32'h3);
    drive(0, 0, 1, 4'he, 2'b11, 4'hc, 1, 1, 1); cyc();
    check("flush_memw", {31'd0, MemWriteM}, 32'h0);
    check("flush_flags", {28'd0, FlagsQ}, 32'h3);

    // reset beats an in-flight branch
    drive(0, 0, 0, 4'he, 2'b00, 4'h0, 1, 0, 0); cyc();
    drive(1, 0, 0, 4'he, 2'b11, 4'hf, 1, 1, 1); cyc();
    check("rst_pcsrcm", {31'd0, PCSrcM}, 32'h0);
    check("rst_flags", {28'd0, FlagsQ}, 32'h0);
`ifdef ALU_COND_PERF_EN
    check("rst_exec", ExecCount, 32'h0);
    check("rst_squash", SquashCount, 32'h0);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 6) == 0, 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
